// File: rtl/systolic_array_controller_if.sv
// Bundle of every non-clock signal of systolic_array_controller.
//   master : host write port, start, and the pe_done return from the PE array.
//   slave  : the controller; drives the edge buses, PE strobes and status.
// Signals:
//   wr_en/wr_b/wr_row/wr_col/wr_data  matrix element write (wr_b=1 selects B)
//   start                             begin a multiply
//   pe_done                           done from PE[0][0]
//   row_data/col_data                 left-edge / top-edge operand buses, 8 bits per lane
//   pe_ready/pe_clear                 PE ready broadcast / accumulator clear
//   busy/done/err                     status, completion pulse, sticky timeout
interface systolic_array_controller_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic            wr_en;
  logic            wr_b;
  logic [IW-1:0]   wr_row;
  logic [IW-1:0]   wr_col;
  logic [7:0]      wr_data;
  logic            start;
  logic            pe_done;
  logic [8*N-1:0]  row_data;
  logic [8*N-1:0]  col_data;
  logic            pe_ready;
  logic            pe_clear;
  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output wr_en, wr_b, wr_row, wr_col, wr_data, start, pe_done,
    input  row_data, col_data, pe_ready, pe_clear, busy, done, err
  );

  modport slave (
    input  wr_en, wr_b, wr_row, wr_col, wr_data, start, pe_done,
    output row_data, col_data, pe_ready, pe_clear, busy, done, err
  );
endinterface

// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N systolic array of bit-serial processing elements.
// Holds matrices A and B, and on start clears the array, then feeds one
// skewed wave per PE cycle: row i of the left edge carries A[i][w-i] and
// column j of the top edge carries B[w-j][j]. After the last of 3N-2 waves
// has been answered by pe_done, done pulses for one cycle.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  systolic_array_controller_if.slave (write port, start, pe_done,
//        edge buses, pe_ready, pe_clear, busy, done, err)
module systolic_array_controller #(
  parameter int N       = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  systolic_array_controller_if.slave  bus
);

  localparam int W  = 3 * N - 2;
  localparam int WW = (W > 1) ? $clog2(W) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  logic [7:0]      a_mem [N][N];
  logic [7:0]      b_mem [N][N];

  logic [2:0]      state_r;
  logic [WW-1:0]   w_r;
  logic [TW-1:0]   tmo_r;
  logic [8*N-1:0]  row_r;
  logic [8*N-1:0]  col_r;
  logic            pe_ready_r;
  logic            pe_clear_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;

  logic [WW-1:0]   w_load_s;
  logic [8*N-1:0]  row_s;
  logic [8*N-1:0]  col_s;

  // Host writes into the A/B banks; dropped while a run is in progress.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_r) begin
      if (bus.wr_b) begin
        b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end else begin
        a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
    end
  end

  // Wave about to be loaded: the bus load at GAP exit belongs to w+1,
  // the one at CLEAR exit to w=0 (w_r is already 0 there).
  assign w_load_s = (state_r == ST_GAP) ? (w_r + WW'(1)) : w_r;

  // Skew mux: lane i shows A[i][k] (lane j shows B[k][j]) when i+k (k+j)
  // equals the wave index, otherwise zero.
  always_comb begin
    row_s = '0;
    col_s = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        row_s[8*i +: 8] = row_s[8*i +: 8] |
                          ((w_load_s == WW'(i + k)) ? a_mem[i][k] : 8'h00);
        col_s[8*i +: 8] = col_s[8*i +: 8] |
                          ((w_load_s == WW'(i + k)) ? b_mem[k][i] : 8'h00);
      end
    end
  end

  // Sequencer FSM with registered strobes, status and edge buses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      w_r        <= '0;
      tmo_r      <= '0;
      row_r      <= '0;
      col_r      <= '0;
      pe_ready_r <= 1'b0;
      pe_clear_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pe_ready_r <= 1'b0;
          pe_clear_r <= 1'b0;
          done_r     <= 1'b0;
          if (bus.start) begin
            state_r    <= ST_CLEAR;
            w_r        <= '0;
            err_r      <= 1'b0;
            pe_clear_r <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          pe_clear_r <= 1'b0;
          row_r      <= row_s;
          col_r      <= col_s;
          pe_ready_r <= 1'b1;
          state_r    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          pe_ready_r <= 1'b0;
          tmo_r      <= '0;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.pe_done) begin
            if (w_r == WW'(W - 1)) begin
              state_r <= ST_FINISH;
              done_r  <= 1'b1;
              row_r   <= '0;
              col_r   <= '0;
            end else begin
              state_r <= ST_GAP;
            end
          end else if (tmo_r == TW'(TIMEOUT - 1)) begin
            // TIMEOUT cycles without an answer: abandon the run.
            state_r <= ST_IDLE;
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            row_r   <= '0;
            col_r   <= '0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_GAP: begin
          // Covers the PE's DONE2 cycle before the next wave is issued.
          w_r        <= w_r + WW'(1);
          row_r      <= row_s;
          col_r      <= col_s;
          pe_ready_r <= 1'b1;
          state_r    <= ST_ISSUE;
        end
        ST_FINISH: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          row_r      <= '0;
          col_r      <= '0;
          pe_ready_r <= 1'b0;
          pe_clear_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.row_data = row_r;
  assign bus.col_data = col_r;
  assign bus.pe_ready = pe_ready_r;
  assign bus.pe_clear = pe_clear_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule
